seg_display_sched: RTL and testbench

- Scheduler that shares the single 3-digit hex 7-segment display between three requesters: live position (default), setpoint (shown briefly after each change) and fault code (highest priority, blinking, req/ack handshake).
- Outputs a 12-bit hex word plus a blank flag. These drive the 7-segment decoder's 12-bit data input; blanking is applied downstream.
- Display contents change only on an internal refresh tick, which limits flicker and readout jitter.

---
 rtl/seg_display_sched_if.sv | 45 ++++
 rtl/seg_display_sched.sv | 149 ++++++++++++++
 tb/tb_seg_display_sched.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_sched_if.sv
// Request and display bundle for the 7-segment display scheduler.
// DISP_LAMP_TEST_EN adds the lamp_test request.
interface seg_display_sched_if;
    logic [11:0] live_val;
    logic [11:0] set_val;
    logic        set_strobe;
    logic        fault_req;
    logic [11:0] fault_code;
    logic        fault_ack;
    logic [11:0] disp_data;
    logic        disp_blank;
    logic [1:0]  disp_src;
    logic        refresh_tick;
`ifdef DISP_LAMP_TEST_EN
    logic        lamp_test;

    modport master (
        output live_val, set_val, set_strobe,
        output fault_req, fault_code, lamp_test,
        input  fault_ack, disp_data, disp_blank,
        input  disp_src, refresh_tick
    );

    modport slave (
        input  live_val, set_val, set_strobe,
        input  fault_req, fault_code, lamp_test,
        output fault_ack, disp_data, disp_blank,
        output disp_src, refresh_tick
    );
`else
    modport master (
        output live_val, set_val, set_strobe,
        output fault_req, fault_code,
        input  fault_ack, disp_data, disp_blank,
        input  disp_src, refresh_tick
    );

    modport slave (
        input  live_val, set_val, set_strobe,
        input  fault_req, fault_code,
        output fault_ack, disp_data, disp_blank,
        output disp_src, refresh_tick
    );
`endif
endinterface

// File: rtl/seg_display_sched.sv
// Shares one 3-digit display between live value, setpoint and fault code.
// DISP_LAMP_TEST_EN adds a lamp test override (disp_src=3).
module seg_display_sched #(
    parameter int REFRESH_DIV = 500000,
    parameter int HOLD_TICKS  = 100,
    parameter int FAULT_TICKS = 200,
    parameter int BLINK_TICKS = 25
) (
    input logic clk,
    input logic rst,
    seg_display_sched_if.slave bus
);
    localparam int RW   = $clog2(REFRESH_DIV);
    localparam int DMAX = (HOLD_TICKS > FAULT_TICKS) ? HOLD_TICKS : FAULT_TICKS;
    localparam int DW   = $clog2(DMAX + 1);
    localparam int BW   = $clog2(BLINK_TICKS + 1);

    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] H_LAST = DW'(HOLD_TICKS - 1);
    localparam logic [DW-1:0] F_LAST = DW'(FAULT_TICKS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_TICKS - 1);

    localparam logic [1:0] S_LIVE  = 2'd0;
    localparam logic [1:0] S_SETPT = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]    state;
    logic [RW-1:0] rcnt;
    logic          tick;
    logic [DW-1:0] dwell;
    logic [BW-1:0] blink;
    logic          phase;
    logic          set_pending;
    logic [11:0]   set_lat;
    logic [11:0]   flt_lat;
    logic          ack;
    logic [11:0]   data;
    logic          blank;
    logic [1:0]    src;
    logic          f_done;
    logic          go_fault;

    assign f_done   = tick && (dwell == F_LAST);
    // Fault is ignored while showing one, except at the exit tick.
    assign go_fault = bus.fault_req && (state != S_FAULT || f_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LIVE;
            rcnt        <= '0;
            tick        <= 1'b0;
            dwell       <= '0;
            blink       <= '0;
            phase       <= 1'b0;
            set_pending <= 1'b0;
            set_lat     <= '0;
            flt_lat     <= '0;
            ack         <= 1'b0;
            data        <= '0;
            blank       <= 1'b0;
            src         <= S_LIVE;
        end else begin
            tick <= (rcnt == R_LAST);
            rcnt <= (rcnt == R_LAST) ? '0 : rcnt + 1'b1;
            ack  <= 1'b0;

            if (bus.set_strobe) set_lat <= bus.set_val;

            if (go_fault) begin
                state   <= S_FAULT;
                flt_lat <= bus.fault_code;
                dwell   <= '0;
                blink   <= '0;
                phase   <= 1'b0;
                ack     <= 1'b1;
                if (bus.set_strobe) set_pending <= 1'b1;
            end else begin
                case (state)
                    S_LIVE: begin
                        if (bus.set_strobe) begin
                            state <= S_SETPT;
                            dwell <= '0;
                        end
                    end
                    S_SETPT: begin
                        if (bus.set_strobe) begin
                            dwell <= '0;
                        end else if (tick) begin
                            if (dwell == H_LAST) state <= S_LIVE;
                            else dwell <= dwell + 1'b1;
                        end
                    end
                    S_FAULT: begin
                        if (tick) begin
                            blink <= (blink == B_LAST) ? '0 : blink + 1'b1;
                            if (blink == B_LAST) phase <= ~phase;
                        end
                        if (f_done) begin
                            if (set_pending || bus.set_strobe) begin
                                state       <= S_SETPT;
                                set_pending <= 1'b0;
                                dwell       <= '0;
                            end else begin
                                state <= S_LIVE;
                            end
                        end else begin
                            if (tick) dwell <= dwell + 1'b1;
                            if (bus.set_strobe) set_pending <= 1'b1;
                        end
                    end
                    default: state <= S_LIVE;
                endcase
            end

`ifdef DISP_LAMP_TEST_EN
            if (bus.lamp_test) begin
                data  <= 12'h888;
                blank <= 1'b0;
                src   <= 2'd3;
            end else
`endif
            if (tick) begin
                case (state)
                    S_LIVE: begin
                        data  <= bus.live_val;
                        blank <= 1'b0;
                        src   <= S_LIVE;
                    end
                    S_SETPT: begin
                        data  <= set_lat;
                        blank <= 1'b0;
                        src   <= S_SETPT;
                    end
                    default: begin
                        data  <= flt_lat;
                        blank <= phase;
                        src   <= S_FAULT;
                    end
                endcase
            end
        end
    end

    assign bus.fault_ack    = ack;
    assign bus.disp_data    = data;
    assign bus.disp_blank   = blank;
    assign bus.disp_src     = src;
    assign bus.refresh_tick = tick;
endmodule

// File: tb/tb_seg_display_sched.sv
// Directed bench for seg_display_sched with a 4-cycle refresh.
// Build with DISP_LAMP_TEST_EN to cover the lamp test.
module tb_seg_display_sched;
    localparam int RD = 4;
    localparam int HT = 3;
    localparam int FT = 4;
    localparam int BT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int ack_cnt = 0;
    logic [3:0] bpat = 4'b1100;

    seg_display_sched_if bus();

    seg_display_sched #(
        .REFRESH_DIV(RD),
        .HOLD_TICKS(HT),
        .FAULT_TICKS(FT),
        .BLINK_TICKS(BT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.fault_ack) ack_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic next_disp();
        int n = 0;
        while (!bus.refresh_tick && n < 8) begin
            step();
            n++;
        end
        if (!bus.refresh_tick) chk("tick_timeout", 32'(bus.refresh_tick), 1);
        step();
    endtask

    task automatic exp_disp(input string tag, input logic [1:0] s,
                            input logic [11:0] d, input logic b);
        next_disp();
        chk({tag, "_src"}, 32'(bus.disp_src), 32'(s));
        chk({tag, "_data"}, 32'(bus.disp_data), 32'(d));
        chk({tag, "_blank"}, 32'(bus.disp_blank), 32'(b));
    endtask

    task automatic fault_seq(input string tag, input logic [11:0] code);
        for (int i = 0; i < 4; i++) exp_disp(tag, 2'd2, code, bpat[i]);
    endtask

    task automatic first_tick(input string tag);
        int n = 0;
        while (!bus.refresh_tick && n < 8) begin
            step();
            n++;
        end
        chk(tag, 32'(n), RD);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: no finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.live_val   = 12'h1A5;
        bus.set_val    = '0;
        bus.set_strobe = 1'b0;
        bus.fault_req  = 1'b0;
        bus.fault_code = '0;
`ifdef DISP_LAMP_TEST_EN
        bus.lamp_test  = 1'b0;
`endif
        repeat (3) step();
        chk("rst_data", 32'(bus.disp_data), 0);
        chk("rst_src", 32'(bus.disp_src), 0);
        chk("rst_blank", 32'(bus.disp_blank), 0);
        chk("rst_ack", 32'(bus.fault_ack), 0);
        chk("rst_tick", 32'(bus.refresh_tick), 0);
        rst = 1'b0;

        first_tick("first_tick");
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.refresh_tick && n < 8);
        chk("period", 32'(n), RD);
        step();
        chk("live_data", 32'(bus.disp_data), 32'h1A5);
        chk("live_src", 32'(bus.disp_src), 0);
        chk("live_blank", 32'(bus.disp_blank), 0);
        bus.live_val = 12'h3F0;
        exp_disp("live2", 2'd0, 12'h3F0, 1'b0);
        bus.live_val = 12'h1A5;

        bus.set_val = 12'h2C0;
        bus.set_strobe = 1'b1;
        step();
        bus.set_strobe = 1'b0;
        for (int i = 0; i < HT; i++) exp_disp("setpt", 2'd1, 12'h2C0, 1'b0);
        exp_disp("setpt_end", 2'd0, 12'h1A5, 1'b0);

        bus.set_strobe = 1'b1;
        step();
        bus.set_strobe = 1'b0;
        exp_disp("rs_first", 2'd1, 12'h2C0, 1'b0);
        bus.set_val = 12'h2C5;
        bus.set_strobe = 1'b1;
        step();
        bus.set_strobe = 1'b0;
        for (int i = 0; i < HT; i++) exp_disp("rs_hold", 2'd1, 12'h2C5, 1'b0);
        exp_disp("rs_end", 2'd0, 12'h1A5, 1'b0);
        chk("ack_none", 32'(ack_cnt), 0);

        bus.fault_code = 12'hE07;
        bus.fault_req = 1'b1;
        step();
        chk("f_ack_hi", 32'(bus.fault_ack), 1);
        bus.fault_req = 1'b0;
        step();
        chk("f_ack_lo", 32'(bus.fault_ack), 0);
        fault_seq("fault", 12'hE07);
        exp_disp("fault_end", 2'd0, 12'h1A5, 1'b0);
        chk("f_ack_cnt", 32'(ack_cnt), 1);

        bus.fault_code = 12'h0B2;
        bus.fault_req = 1'b1;
        bus.set_val = 12'h300;
        bus.set_strobe = 1'b1;
        step();
        chk("fs_ack", 32'(bus.fault_ack), 1);
        bus.fault_req = 1'b0;
        bus.set_strobe = 1'b0;
        fault_seq("fs_fault", 12'h0B2);
        for (int i = 0; i < HT; i++) exp_disp("fs_setpt", 2'd1, 12'h300, 1'b0);
        exp_disp("fs_end", 2'd0, 12'h1A5, 1'b0);
        chk("fs_ack_cnt", 32'(ack_cnt), 2);

        bus.fault_code = 12'hE07;
        bus.fault_req = 1'b1;
        step();
        chk("hold_ack1", 32'(bus.fault_ack), 1);
        exp_disp("hold_a", 2'd2, 12'hE07, 1'b0);
        bus.fault_code = 12'hE08;
        exp_disp("hold_b", 2'd2, 12'hE07, 1'b0);
        exp_disp("hold_c", 2'd2, 12'hE07, 1'b1);
        exp_disp("hold_d", 2'd2, 12'hE07, 1'b1);
        chk("hold_ack2", 32'(bus.fault_ack), 1);
        bus.fault_req = 1'b0;
        fault_seq("hold_re", 12'hE08);
        exp_disp("hold_end", 2'd0, 12'h1A5, 1'b0);
        chk("hold_ack_cnt", 32'(ack_cnt), 4);

        bus.fault_code = 12'hE07;
        bus.fault_req = 1'b1;
        step();
        bus.fault_req = 1'b0;
        exp_disp("mr_fault", 2'd2, 12'hE07, 1'b0);
        rst = 1'b1;
        bus.fault_req = 1'b1;
        step();
        chk("mr_data", 32'(bus.disp_data), 0);
        chk("mr_src", 32'(bus.disp_src), 0);
        chk("mr_blank", 32'(bus.disp_blank), 0);
        chk("mr_ack", 32'(bus.fault_ack), 0);
        chk("mr_tick", 32'(bus.refresh_tick), 0);
        rst = 1'b0;
        bus.fault_req = 1'b0;
        first_tick("mr_first_tick");
        step();
        chk("mr_live_src", 32'(bus.disp_src), 0);
        chk("mr_live_data", 32'(bus.disp_data), 32'h1A5);
        step();
        chk("mr_ack_cnt", 32'(ack_cnt), 5);

`ifdef DISP_LAMP_TEST_EN
        bus.lamp_test = 1'b1;
        step();
        chk("lamp_data", 32'(bus.disp_data), 32'h888);
        chk("lamp_src", 32'(bus.disp_src), 3);
        chk("lamp_blank", 32'(bus.disp_blank), 0);
        bus.fault_req = 1'b1;
        step();
        chk("lamp_ack", 32'(bus.fault_ack), 1);
        chk("lamp_src2", 32'(bus.disp_src), 3);
        bus.fault_req = 1'b0;
        bus.lamp_test = 1'b0;
        exp_disp("lamp_off", 2'd2, 12'hE07, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
